// File: rtl/fmul_wb_buffer_pkg.sv
// Shared FPU constants for the multiplier writeback path.
// Holds the float word width and the default destination-tag width.
package fmul_wb_buffer_pkg;

  localparam int FP_W  = 32;
  localparam int TAG_W = 5;

endpackage

// File: rtl/fmul_wb_mem.sv
// Storage for the multiplier writeback buffer.
// DEPTH x W register array with one write port and one asynchronous read port.
module fmul_wb_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are never reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fmul_wb_buffer.sv
// FIFO between the FP multiplier and the register-file writeback port.
// Adds a sticky exponent-overflow flag and a flush that empties the queue.
module fmul_wb_buffer
  import fmul_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FP_W-1:0]          in_y,
  input  logic                     in_ovf,
  input  logic [TAGW-1:0]          in_rd,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [FP_W-1:0]          wb_data,
  output logic [TAGW-1:0]          wb_rd,
  input  logic                     flush,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = FP_W + TAGW;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Readiness never looks at wb_ready, so a full buffer stalls even while draining.
  assign in_ready = !rst && (count != CW'(DEPTH)) && !flush;
  assign wb_valid = (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready && !flush;

  fmul_wb_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_y, in_rd}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign wb_data = head[EW-1:TAGW];
  assign wb_rd   = head[TAGW-1:0];

  // Flush wins over any pop; push cannot coincide because in_ready drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A new overflow beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ovf_sticky <= 1'b0;
    else if (push && in_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)        ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_fmul_wb_buffer.sv
// Self-checking bench for fmul_wb_buffer against a queue-based reference model.
// Directed scenarios first, then a randomized traffic phase.
module tb_fmul_wb_buffer;

  localparam int DEPTH = 4;
  localparam int TAGW  = 5;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_y;
  logic            in_ovf;
  logic [TAGW-1:0] in_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [TAGW-1:0] wb_rd;
  logic            flush;
  logic            ovf_sticky;
  logic            ovf_clr;
  logic [2:0]      count;

  int errors;
  int checks;

  logic [36:0] mq[$];
  bit          msticky;

  fmul_wb_buffer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_ovf     (in_ovf),
    .in_rd      (in_rd),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check outputs against the model, advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] y, input logic o,
                               input logic [TAGW-1:0] r, input logic wr,
                               input logic f, input logic c);
    bit exp_rdy;
    bit do_push;
    bit do_pop;
    in_valid = v; in_y = y; in_ovf = o; in_rd = r;
    wb_ready = wr; flush = f; ovf_clr = c;
    @(negedge clk);
    exp_rdy = (mq.size() != DEPTH) && !f;
    checkOutput("in_ready", in_ready, exp_rdy);
    checkOutput("wb_valid", wb_valid, mq.size() != 0);
    checkOutput("count", count, mq.size());
    checkOutput("ovf_sticky", ovf_sticky, msticky);
    if (mq.size() != 0) begin
      checkOutput("wb_data", wb_data, mq[0][36:5]);
      checkOutput("wb_rd", wb_rd, mq[0][4:0]);
    end
    do_push = v && exp_rdy;
    do_pop  = (mq.size() != 0) && wr && !f;
    if (f) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({y, r});
    end
    if (do_push && o) msticky = 1'b1;
    else if (c) msticky = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_empty", mq.size(), 0);
  endtask

  task automatic pushOne(input logic [31:0] y, input logic [TAGW-1:0] r, input logic o);
    applyStimulus(1'b1, y, o, r, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    msticky = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; in_y = '0; in_ovf = 1'b0; in_rd = '0;
    wb_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_ovf", ovf_sticky, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single push becomes visible one cycle later.
    pushOne(32'h40400000, 5'd3, 1'b0);
    checkOutput("t1_valid", wb_valid, 1);
    checkOutput("t1_data", wb_data, 32'h40400000);
    checkOutput("t1_rd", wb_rd, 3);
    checkOutput("t1_count", count, 1);
    drain();

    // Fill to DEPTH, reject a fifth, then drain in order.
    for (int i = 0; i < DEPTH; i++) pushOne(32'h3F800000 + i, TAGW'(i + 8), 1'b0);
    checkOutput("t2_full_count", count, 4);
    checkOutput("t2_full_ready", in_ready, 0);
    pushOne(32'hDEADBEEF, 5'd31, 1'b0);
    checkOutput("t2_ignored", count, 4);
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_ready_after_pop", in_ready, 1);
    drain();

    // Simultaneous push and pop at count=2.
    pushOne(32'h11111111, 5'd1, 1'b0);
    pushOne(32'h22222222, 5'd2, 1'b0);
    applyStimulus(1'b1, 32'h33333333, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_count", count, 2);
    checkOutput("t3_head", wb_data, 32'h22222222);
    drain();

    // Sticky overflow: set, set-beats-clear, clear alone.
    pushOne(32'h7F800000, 5'd4, 1'b1);
    checkOutput("t4_set", ovf_sticky, 1);
    applyStimulus(1'b1, 32'h7F800000, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_set_wins", ovf_sticky, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_clear", ovf_sticky, 0);
    drain();

    // Flush with push and pop attempts at count=3; sticky kept.
    pushOne(32'h7F800001, 5'd6, 1'b1);
    pushOne(32'h12345678, 5'd7, 1'b0);
    pushOne(32'h87654321, 5'd8, 1'b0);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_count", count, 0);
    checkOutput("t5_valid", wb_valid, 0);
    checkOutput("t5_ovf", ovf_sticky, 1);

    // Asynchronous reset mid-cycle at count=2.
    pushOne(32'hAAAA0000, 5'd10, 1'b0);
    pushOne(32'hBBBB0000, 5'd11, 1'b0);
    in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_valid", wb_valid, 0);
    checkOutput("t6_count", count, 0);
    checkOutput("t6_ready", in_ready, 0);
    checkOutput("t6_ovf", ovf_sticky, 0);
    mq.delete();
    msticky = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      pushOne($urandom, TAGW'($urandom), 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic including occasional flush and clear.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
                    TAGW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmul_wb_buffer.md
FMUL_WB_BUFFER -- requirements
Module: fmul_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter TAGW, default 5, width of the destination-register tag.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  multiplier result present this cycle.
REQ-006 in_ready  output  1  buffer accepts a result this cycle.
REQ-007 in_y  input  32  single-precision product from the multiplier.
REQ-008 in_ovf  input  1  exponent-overflow flag from the multiplier.
REQ-009 in_rd  input  TAGW  destination FP register tag.
REQ-010 wb_valid  output  1  head entry presented for writeback.
REQ-011 wb_ready  input  1  register file accepts the head entry.
REQ-012 wb_data  output  32  head entry product.
REQ-013 wb_rd  output  TAGW  head entry tag.
REQ-014 flush  input  1  discard all queued entries.
REQ-015 ovf_sticky  output  1  an accepted result carried in_ovf since the last clear.
REQ-016 ovf_clr  input  1  clear ovf_sticky.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when wb_valid and wb_ready are both high.
REQ-019 in_ready SHALL equal (count != DEPTH) and (not flush); it SHALL NOT depend on wb_ready.
REQ-020 wb_valid SHALL equal (count != 0).
REQ-021 wb_data and wb_rd SHALL be driven from the head storage entry; their values are don't-care when wb_valid is low.
REQ-022 A push into an empty buffer SHALL raise wb_valid on the following cycle (latency 1); there is no same-cycle bypass.
REQ-023 Entries SHALL pop in push order (FIFO); stored in_y and in_rd SHALL be unmodified.
REQ-024 Storage SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 When full, in_ready SHALL be low; a pop in that cycle SHALL still occur, and in_ready SHALL be high the next cycle.
REQ-027 When empty, wb_ready SHALL have no effect.
REQ-028 flush SHALL take priority: next cycle count=0, pointers equal, wb_valid=0; any same-cycle pop is discarded, and no push is possible because in_ready is low.
REQ-029 ovf_sticky SHALL be set on the cycle after a push with in_ovf=1.
REQ-030 ovf_clr SHALL clear ovf_sticky on the next cycle, and a same-cycle set SHALL win over a clear.
REQ-031 flush SHALL NOT affect ovf_sticky.
REQ-032 Pushes attempted while in_ready is low SHALL be ignored; the upstream stage holds its data.

Reset
REQ-033 While rst is high: count=0, both pointers=0, wb_valid=0, in_ready=0, ovf_sticky=0.
REQ-034 The first cycle after rst deasserts SHALL have in_ready=1 unless flush is high.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, with no pop reported.
REQ-036 Storage array contents need not be reset.

Structure
REQ-037 The shared FPU package SHALL hold FP_W=32 and the default tag width; DEPTH stays a module parameter.
REQ-038 One sub-module, fmul_wb_mem (a DEPTH x (32+TAGW) register array with one write port and one async read port), is natural; pointer, count and flag logic stay in fmul_wb_buffer.

Verification
REQ-039 Test 1: push 0x40400000 rd=3, hold wb_ready=0 -> next cycle wb_valid=1, wb_data=0x40400000, wb_rd=3, count=1.
REQ-040 Test 2: with wb_ready=0, push 4 results (DEPTH=4) -> count=4, in_ready=0; a 5th in_valid is ignored; assert wb_ready -> pops return the 4 values in order, and in_ready=1 the cycle after the first pop.
REQ-041 Test 3: at count=2, push and pop in the same cycle -> count stays 2, and the head advances to the second entry.
REQ-042 Test 4: push in_y=0x7F800000 with in_ovf=1 -> ovf_sticky=1 next cycle; assert ovf_clr together with another in_ovf=1 push -> ovf_sticky stays 1; assert ovf_clr alone -> ovf_sticky=0.
REQ-043 Test 5: at count=3, assert flush together with in_valid and wb_ready -> in_ready=0 that cycle; next cycle count=0, wb_valid=0, ovf_sticky unchanged.
REQ-044 Test 6: at count=2, assert rst asynchronously mid-cycle -> wb_valid=0 and count=0 before the next edge; after release, 10 push/pop pairs exercise pointer wrap with no data loss.
